channel_fir_cmplx: RTL and testbench

Complex-coefficient FIR channel filter sitting directly downstream of the IQ byte reader in the FM radio datapath. It pops one quantized I sample and one quantized Q sample per input step from two FIFOs, shifts them into a TAPS-deep complex delay line, and performs one complex multiply-accumulate per tap per cycle. Every DECIM input samples it writes one filtered real/imag pair to two output FIFOs for the demodulator. Coefficients are loaded at run time through a small write port.

---
 rtl/channel_fir_cmplx.sv | 205 ++++++++++++++++++++
 tb/tb_channel_fir_cmplx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_fir_cmplx.sv
// Complex-coefficient FIR channel filter.
// Pops paired I/Q samples into a TAPS-deep complex delay line. After every
// DECIM pops it runs one complex multiply-accumulate per tap per cycle, then
// pushes one filtered real/imag pair to the output FIFOs.
module channel_fir_cmplx #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter int TAPS      = 20,
    parameter int DECIM     = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_SIZE-1:0]     i_in,
    input  logic [DATA_SIZE-1:0]     q_in,
    input  logic                     i_empty,
    input  logic                     q_empty,
    output logic                     i_rd_en,
    output logic                     q_rd_en,
    input  logic                     coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [DATA_SIZE-1:0]     coef_real,
    input  logic [DATA_SIZE-1:0]     coef_imag,
    input  logic                     real_full,
    input  logic                     imag_full,
    output logic                     out_wr_en,
    output logic [DATA_SIZE-1:0]     y_real_out,
    output logic [DATA_SIZE-1:0]     y_imag_out
);

    localparam int AW = $clog2(TAPS);
    localparam int CW = $clog2(DECIM + 1);
    localparam int PW = 2 * DATA_SIZE;

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [AW:0]   TAP_LIM  = (AW + 1)'(TAPS);
    localparam logic [CW-1:0] DECIM_W  = CW'(DECIM);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic signed [DATA_SIZE-1:0] x_re_r [TAPS];
    logic signed [DATA_SIZE-1:0] x_im_r [TAPS];
    logic signed [DATA_SIZE-1:0] h_re_r [TAPS];
    logic signed [DATA_SIZE-1:0] h_im_r [TAPS];

    logic [AW-1:0]               tap_r;
    logic [CW-1:0]               cnt_r;
    logic signed [DATA_SIZE-1:0] acc_re_r;
    logic signed [DATA_SIZE-1:0] acc_im_r;
    logic signed [DATA_SIZE-1:0] y_re_r;
    logic signed [DATA_SIZE-1:0] y_im_r;

    logic pop_s;
    logic group_done_s;
    logic last_tap_s;
    logic coef_we_s;
    logic wr_ok_s;

    logic signed [PW-1:0]        prod_rr_s;
    logic signed [PW-1:0]        prod_ii_s;
    logic signed [PW-1:0]        prod_ri_s;
    logic signed [PW-1:0]        prod_ir_s;
    logic signed [PW-1:0]        diff_re_s;
    logic signed [PW-1:0]        diff_im_s;
    logic signed [PW-1:0]        shr_re_s;
    logic signed [PW-1:0]        shr_im_s;
    logic signed [DATA_SIZE-1:0] acc_re_next_s;
    logic signed [DATA_SIZE-1:0] acc_im_next_s;

    // Sign-extend a sample or coefficient to full product width.
    function automatic logic signed [PW-1:0] sext(input logic signed [DATA_SIZE-1:0] v);
        return {{DATA_SIZE{v[DATA_SIZE-1]}}, v};
    endfunction

    // Both FIFOs are popped together only; reset masks the pop so nothing is lost.
    assign pop_s        = (state_r == ST_LOAD) && !i_empty && !q_empty && !reset;
    assign group_done_s = pop_s && ((cnt_r + CW'(1)) == DECIM_W);
    assign last_tap_s   = (tap_r == LAST_TAP);
    assign coef_we_s    = coef_wr_en && (state_r == ST_LOAD) && !reset
                          && ({1'b0, coef_addr} < TAP_LIM);
    assign wr_ok_s      = !real_full && !imag_full;

    assign i_rd_en    = pop_s;
    assign q_rd_en    = pop_s;
    assign out_wr_en  = (state_r == ST_WRITE) && wr_ok_s;
    assign y_real_out = y_re_r;
    assign y_imag_out = y_im_r;

    // One complex MAC term for the current tap; the imag difference keeps the
    // sign convention of the software reference model.
    always_comb begin
        prod_rr_s     = sext(h_re_r[tap_r]) * sext(x_re_r[tap_r]);
        prod_ii_s     = sext(h_im_r[tap_r]) * sext(x_im_r[tap_r]);
        prod_ri_s     = sext(h_re_r[tap_r]) * sext(x_im_r[tap_r]);
        prod_ir_s     = sext(h_im_r[tap_r]) * sext(x_re_r[tap_r]);
        diff_re_s     = prod_rr_s - prod_ii_s;
        diff_im_s     = prod_ri_s - prod_ir_s;
        shr_re_s      = diff_re_s >>> BITS;
        shr_im_s      = diff_im_s >>> BITS;
        acc_re_next_s = acc_re_r + shr_re_s[DATA_SIZE-1:0];
        acc_im_next_s = acc_im_r + shr_im_s[DATA_SIZE-1:0];
    end

    // Next-state selection; unknown encodings fall back to LOAD.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (group_done_s) state_next_s = ST_COMPUTE;
                else              state_next_s = ST_LOAD;
            end
            ST_COMPUTE: begin
                if (last_tap_s) state_next_s = ST_WRITE;
                else            state_next_s = ST_COMPUTE;
            end
            ST_WRITE: begin
                if (wr_ok_s) state_next_s = ST_LOAD;
                else         state_next_s = ST_WRITE;
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= ST_LOAD;
        else       state_r <= state_next_s;
    end

    // Sample counter, tap index, accumulators and held output pair.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r    <= '0;
            tap_r    <= '0;
            acc_re_r <= '0;
            acc_im_r <= '0;
            y_re_r   <= '0;
            y_im_r   <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (group_done_s) begin
                        cnt_r    <= '0;
                        tap_r    <= '0;
                        acc_re_r <= '0;
                        acc_im_r <= '0;
                    end else if (pop_s) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_COMPUTE: begin
                    acc_re_r <= acc_re_next_s;
                    acc_im_r <= acc_im_next_s;
                    if (last_tap_s) begin
                        tap_r  <= '0;
                        y_re_r <= acc_re_next_s;
                        y_im_r <= acc_im_next_s;
                    end else begin
                        tap_r <= tap_r + AW'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Complex delay line: newest sample enters at tap 0, oldest falls off the end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_re_r[k] <= '0;
                x_im_r[k] <= '0;
            end
        end else if (pop_s) begin
            x_re_r[0] <= i_in;
            x_im_r[0] <= q_in;
            for (int k = 1; k < TAPS; k++) begin
                x_re_r[k] <= x_re_r[k-1];
                x_im_r[k] <= x_im_r[k-1];
            end
        end
    end

    // Coefficient file, writable only while waiting for input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                h_re_r[k] <= '0;
                h_im_r[k] <= '0;
            end
        end else if (coef_we_s) begin
            h_re_r[coef_addr] <= coef_real;
            h_im_r[coef_addr] <= coef_imag;
        end
    end

endmodule

// File: tb/tb_channel_fir_cmplx.sv
// Self-checking bench for channel_fir_cmplx: FIFO-like sources/sinks driven
// from queues, a sample-history filter model checked every cycle, and a few
// hand-computed output values.
module tb_channel_fir_cmplx;

    localparam int DS    = 32;
    localparam int BITS  = 10;
    localparam int TAPS  = 20;
    localparam int DECIM = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DS-1:0] i_in = '0, q_in = '0;
    logic          i_empty = 1'b1, q_empty = 1'b1;
    logic          i_rd_en, q_rd_en;
    logic          coef_wr_en = 1'b0;
    logic [4:0]    coef_addr = '0;
    logic [DS-1:0] coef_real = '0, coef_imag = '0;
    logic          real_full = 1'b0, imag_full = 1'b0;
    logic          out_wr_en;
    logic [DS-1:0] y_real_out, y_imag_out;

    channel_fir_cmplx #(.DATA_SIZE(DS), .BITS(BITS), .TAPS(TAPS), .DECIM(DECIM)) dut (
        .clock(clock), .reset(reset),
        .i_in(i_in), .q_in(q_in), .i_empty(i_empty), .q_empty(q_empty),
        .i_rd_en(i_rd_en), .q_rd_en(q_rd_en),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
        .coef_real(coef_real), .coef_imag(coef_imag),
        .real_full(real_full), .imag_full(imag_full),
        .out_wr_en(out_wr_en), .y_real_out(y_real_out), .y_imag_out(y_imag_out)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    // environment
    int src_i[$], src_q[$];
    int cw_addr[$], cw_re[$], cw_im[$];
    bit knob_rst = 1'b1, knob_gaps = 1'b0, knob_rcoef = 1'b0, knob_skew = 1'b0;
    int knob_full = 0;
    int out_count = 0, rd_count = 0;
    int cap_re[$], cap_im[$];

    // behavioural model: coefficient file, full sample history since reset,
    // pending-pop count, remaining compute cycles, write-pending flag
    int m_hr[TAPS], m_hi[TAPS];
    int m_hist_r[$], m_hist_i[$];
    int m_pops = 0, m_cl = 0;
    bit m_wr = 1'b0;
    int m_yr = 0, m_yi = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin m_hr[k] = 0; m_hi[k] = 0; end
        m_hist_r.delete(); m_hist_i.delete();
        m_pops = 0; m_cl = 0; m_wr = 1'b0; m_yr = 0; m_yi = 0;
    endfunction

    // y = sum_k (h[k] * x[n-1-k]) with per-term shift and 32-bit wraparound
    function automatic void model_filter();
        int n, ar, ai, xr, xi;
        longint dr, di;
        n = m_hist_r.size(); ar = 0; ai = 0;
        for (int k = 0; k < TAPS; k++) begin
            xr = 0; xi = 0;
            if (n - 1 - k >= 0) begin xr = m_hist_r[n-1-k]; xi = m_hist_i[n-1-k]; end
            dr = longint'(m_hr[k]) * longint'(xr) - longint'(m_hi[k]) * longint'(xi);
            di = longint'(m_hr[k]) * longint'(xi) - longint'(m_hi[k]) * longint'(xr);
            ar += int'(dr >>> BITS);
            ai += int'(di >>> BITS);
        end
        m_yr = ar; m_yi = ai;
    endfunction

    // One clock: drive at negedge, check and advance the model 1ns later.
    task automatic run(input int n);
        bit lp, erd, ewr, cw, have;
        int ca, cr, ci;
        repeat (n) begin
            @(negedge clock);
            reset = knob_rst;
            if (knob_skew) begin
                i_empty = 1'b0; q_empty = 1'b1; i_in = $urandom; q_in = $urandom;
            end else begin
                have = (src_i.size() > 0);
                i_in = have ? src_i[0] : $urandom;
                q_in = have ? src_q[0] : $urandom;
                i_empty = !have || (knob_gaps && $urandom_range(3) == 0);
                q_empty = !have || (knob_gaps && $urandom_range(3) == 0);
            end
            case (knob_full)
                1:       begin real_full = ($urandom_range(3) == 0); imag_full = ($urandom_range(3) == 0); end
                2:       begin real_full = 1'b1; imag_full = 1'b0; end
                default: begin real_full = 1'b0; imag_full = 1'b0; end
            endcase
            cw = 1'b0; ca = $urandom_range(TAPS - 1); cr = $urandom; ci = $urandom;
            if (cw_addr.size() > 0) begin
                cw = 1'b1; ca = cw_addr.pop_front(); cr = cw_re.pop_front(); ci = cw_im.pop_front();
            end else if (knob_rcoef && $urandom_range(7) == 0) begin
                cw = 1'b1;
            end
            coef_wr_en = cw; coef_addr = 5'(ca); coef_real = cr; coef_imag = ci;
            #1;
            if (reset) model_reset();
            lp  = !reset && m_cl == 0 && !m_wr;
            erd = lp && !i_empty && !q_empty;
            ewr = !reset && m_wr && !real_full && !imag_full;
            chk("i_rd_en", i_rd_en, erd);
            chk("q_rd_en", q_rd_en, erd);
            chk("out_wr_en", out_wr_en, ewr);
            chk("y_real_out", $signed(y_real_out), m_yr);
            chk("y_imag_out", $signed(y_imag_out), m_yi);
            if (i_rd_en || q_rd_en) rd_count++;
            if (out_wr_en) begin
                out_count++;
                cap_re.push_back(int'($signed(y_real_out)));
                cap_im.push_back(int'($signed(y_imag_out)));
            end
            if (i_rd_en && !knob_skew && src_i.size() > 0) begin
                void'(src_i.pop_front()); void'(src_q.pop_front());
            end
            if (lp && cw && ca < TAPS) begin m_hr[ca] = cr; m_hi[ca] = ci; end
            if (erd) begin
                m_hist_r.push_back(int'(i_in)); m_hist_i.push_back(int'(q_in));
                m_pops++;
                if (m_pops == DECIM) begin m_pops = 0; m_cl = TAPS; end
            end else if (m_cl > 0) begin
                m_cl--;
                if (m_cl == 0) begin model_filter(); m_wr = 1'b1; end
            end else if (ewr) begin
                m_wr = 1'b0;
            end
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int tgt, c;
        tgt = out_count + n; c = 0;
        while (out_count < tgt && c < budget) begin run(1); c++; end
        chk("wait_out_in_budget", out_count >= tgt, 1);
    endtask

    // kind 0: h_r=1024 all, h_i=0; kind 1: h_r=0, h_i[0]=1024; kind 2: random
    task automatic load_coefs(input int kind);
        for (int k = 0; k < TAPS; k++) begin
            cw_addr.push_back(k);
            case (kind)
                0:       begin cw_re.push_back(1024); cw_im.push_back(0); end
                1:       begin cw_re.push_back(0); cw_im.push_back(k == 0 ? 1024 : 0); end
                default: begin cw_re.push_back($urandom); cw_im.push_back($urandom); end
            endcase
        end
        run(TAPS + 1);
    endtask

    task automatic push(input int iv, input int qv);
        src_i.push_back(iv); src_q.push_back(qv);
    endtask

    initial begin
        int base, oc0, rd0, c;

        // reset state
        knob_rst = 1'b1; run(3); knob_rst = 1'b0;
        chk("reset_y_real", $signed(y_real_out), 0);
        run(2);

        // impulse through all-1024 real taps
        load_coefs(0);
        base = cap_re.size();
        push(1024, 0);
        for (int k = 0; k < 29; k++) push(0, 0);
        wait_out(3, 400);
        run(5);
        chk("impulse_count", out_count, base + 3);
        chk("impulse_y0_re", cap_re[base], 1024);     chk("impulse_y0_im", cap_im[base], 0);
        chk("impulse_y1_re", cap_re[base+1], 1024);   chk("impulse_y1_im", cap_im[base+1], 0);
        chk("impulse_y2_re", cap_re[base+2], 0);

        // cross term through h_i[0]
        load_coefs(1);
        base = cap_re.size();
        for (int k = 0; k < 9; k++) push(0, 0);
        push(2048, 3072);
        wait_out(1, 200);
        run(3);
        chk("cross_y_re", cap_re[base], -3072);
        chk("cross_y_im", cap_im[base], -2048);

        // decimation: 100 ramp pairs, random gaps and backpressure
        load_coefs(2);
        knob_gaps = 1'b1; knob_full = 1;
        oc0 = out_count;
        for (int k = 0; k < 100; k++) push(k * 1000 - 31000, 7 - k * 613);
        wait_out(10, 4000);
        run(40);
        chk("decim_output_count", out_count - oc0, 10);

        // random samples with coefficient writes at arbitrary times
        knob_rcoef = 1'b1;
        for (int k = 0; k < 60; k++) push($urandom, $urandom);
        wait_out(6, 4000);
        knob_rcoef = 1'b0; knob_gaps = 1'b0; knob_full = 0;
        run(40);

        // backpressure held for 50 cycles in WRITE with input available
        for (int k = 0; k < 30; k++) push($urandom_range(4095), $urandom_range(4095));
        c = 0;
        while (!m_wr && c < 300) begin run(1); c++; end
        chk("bp_reached_write", m_wr, 1);
        knob_full = 2; oc0 = out_count; rd0 = rd_count;
        run(50);
        chk("bp_no_write", out_count - oc0, 0);
        chk("bp_no_read", rd_count - rd0, 0);
        knob_full = 0;
        run(2);
        chk("bp_single_write", out_count - oc0, 1);
        wait_out(2, 300);
        run(5);

        // I available, Q empty: no pops on either side
        knob_skew = 1'b1; rd0 = rd_count;
        run(20);
        knob_skew = 1'b0;
        chk("skew_no_read", rd_count - rd0, 0);

        // reset while computing tap 7, then restart from clean delay line
        load_coefs(0);
        for (int k = 0; k < 10; k++) push(5000, 7000);
        c = 0;
        while (m_cl != TAPS - 7 && c < 200) begin run(1); c++; end
        chk("rst_reached_tap7", m_cl, TAPS - 7);
        oc0 = out_count;
        knob_rst = 1'b1; run(2);
        src_i.delete(); src_q.delete();
        knob_rst = 1'b0;
        chk("rst_y_real_zero", $signed(y_real_out), 0);
        chk("rst_y_imag_zero", $signed(y_imag_out), 0);
        run(25);
        chk("rst_no_write", out_count - oc0, 0);
        load_coefs(0);
        base = cap_re.size();
        for (int k = 0; k < 10; k++) push(3, 2);
        wait_out(1, 200);
        run(3);
        chk("post_rst_y_re", cap_re[base], 30);
        chk("post_rst_y_im", cap_im[base], 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
